// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide controller: computes the result at issue, models unit
// latency with a down-counter, commits to HI/LO and stalls HI/LO users while busy.
module muldiv_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mul_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_div, is_signed, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, quot, rem;
  logic [31:0] calc_hi, calc_lo;

  assign is_div    = mul_op[1];
  assign is_signed = ~mul_op[0];

  // Low 64 bits of the product of sign/zero-extended operands is the exact result.
  assign a_ext   = {{32{is_signed & rs_val[31]}}, rs_val};
  assign b_ext   = {{32{is_signed & rt_val[31]}}, rt_val};
  assign product = a_ext * b_ext;

  // Signed divide runs on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 r 0.
  assign a_neg   = is_signed & rs_val[31];
  assign b_neg   = is_signed & rt_val[31];
  assign a_mag   = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign b_mag   = b_neg ? (~rt_val + 32'd1) : rt_val;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq      = a_mag / divisor;
  assign ur      = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem     = a_neg ? (~ur + 32'd1) : ur;

  always_comb begin
    calc_hi = product[63:32];
    calc_lo = product[31:0];
    if (is_div) begin
      if (rt_val == 32'd0) begin
        calc_hi = rs_val;
        calc_lo = 32'hFFFF_FFFF;
      end else begin
        calc_hi = rem;
        calc_lo = quot;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = is_div ? DIV_LD : MUL_LD;
          res_hi_d = calc_hi;
          res_lo_d = calc_lo;
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = busy & (start | mthi | mtlo | hilo_rd);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed and random mult/div issues checked
// against an independent arithmetic model through an expected-result queue.
module tb_muldiv_sequencer;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk, reset, start, mthi, mtlo, hilo_rd;
  logic [1:0]  mul_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  logic [63:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;
  int done_cnt     = 0;

  muldiv_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mul_op(mul_op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .hilo_rd(hilo_rd), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'd0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check_val("spurious_done", done, 1'b0);
      else check_val("hilo_result", {hi, lo}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rd_busy, input bit start_busy);
    logic [63:0] hilo0;
    int n;
    hilo0   = {hi, lo};
    mul_op  = op;
    rs_val  = a;
    rt_val  = b;
    start   = 1'b1;
    exp_q.push_back(model(op, a, b));
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    n     = 0;
    while (busy && n < 40) begin
      hilo_rd = rd_busy;
      start   = start_busy;
      if (start_busy) begin
        mul_op = ~op;
        rs_val = $urandom;
      end
      #1;
      check_val("stall_busy", stall, rd_busy | start_busy);
      check_val("hilo_stable", {hi, lo}, hilo0);
      n++;
      tick();
    end
    start = 1'b0;
    #1;
    check_val("stall_idle", stall, 1'b0);
    check_val("done_pulse", done, 1'b1);
    check_val("busy_cycles", 64'(n), 64'(op[1] ? DIV_N : MUL_N));
    hilo_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b1;
    mul_op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    tick();
    check_val("idle_stall", stall, 1'b0);
    hilo_rd = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check_val("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check_val("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check_val("div_neg_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    check_val("div_zero_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_val("div_ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_val("multu_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    tick();
    check_val("no_retrigger", busy, 1'b0);

    // idle HI/LO writes
    rs_val = 32'hA5A5_A5A5; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    check_val("mthi", {hi, lo}, {32'hA5A5_A5A5, 32'd0});
    rs_val = 32'h1234_5678; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check_val("mthi_mtlo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
    mthi = 1'b1;
    run_op(2'b00, 32'h10, 32'h20, 1'b0, 1'b0);
    check_val("start_mthi", {hi, lo}, {32'd0, 32'h200});

    // random issues
    for (int i = 0; i < 10; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(2'($urandom_range(0, 3)), $urandom, b, bit'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // abort in the third RUN cycle
    run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    mul_op = 2'b11; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("abort_in_run", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_hilo", {hi, lo}, 64'd0);
    check_val("abort_done", done, 1'b0);
    #2;
    reset = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      repeat (15) tick();
      check_val("abort_no_done", 64'(done_cnt), 64'(d0));
    end

    check_val("pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
